// File: rtl/ahb_rom_pkg.sv
// Shared types and constants for the AHB ROM controller.
// Optional one-word line buffer is enabled with `define ROM_LINEBUF_EN.
`ifndef AHB_TRANS_BITS
`define AHB_TRANS_BITS 2
`endif
`ifndef AHB_ADDR_BITS
`define AHB_ADDR_BITS 32
`endif
`ifndef AHB_SIZE_BITS
`define AHB_SIZE_BITS 3
`endif
`ifndef AHB_DATA_BITS
`define AHB_DATA_BITS 32
`endif
`ifndef AHB_RESP_BITS
`define AHB_RESP_BITS 2
`endif

package ahb_rom_pkg;

  // Controller data-phase states
  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    WAIT,
    DATA,
    ERR1,
    ERR2
  } rom_state_e;

  // Wait counter covers WAIT_CYCLES in 0..7
  localparam int WAIT_CNT_W = 3;

  // Word index carried around the design: byte address without the low two bits
  localparam int ROM_WORD_IDX_W = `AHB_ADDR_BITS - 2;

  localparam logic [`AHB_TRANS_BITS-1:0] HTRANS_NONSEQ = `AHB_TRANS_BITS'(2);
  localparam logic [`AHB_TRANS_BITS-1:0] HTRANS_SEQ    = `AHB_TRANS_BITS'(3);

  localparam logic [`AHB_RESP_BITS-1:0] HRESP_OKAY  = `AHB_RESP_BITS'(0);
  localparam logic [`AHB_RESP_BITS-1:0] HRESP_ERROR = `AHB_RESP_BITS'(1);

  // Number of word-index bits addressed by a ROM of the given depth
  function automatic int rom_idx_bits(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/ahb_rom_linebuf.sv
// One-entry read buffer (word index, data, valid) for the AHB ROM controller.
// Only instantiated when ROM_LINEBUF_EN is defined.
module ahb_rom_linebuf
  import ahb_rom_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [ROM_WORD_IDX_W-1:0] load_idx,
  input  logic [31:0]               load_data,
  input  logic [ROM_WORD_IDX_W-1:0] lookup_idx,
  output logic                      hit,
  output logic [31:0]               data
);

  logic                      valid_reg;
  logic [ROM_WORD_IDX_W-1:0] idx_reg;
  logic [31:0]               data_reg;

  // Capture the word being returned from ROM; reset invalidates the entry
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      idx_reg   <= '0;
      data_reg  <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      idx_reg   <= load_idx;
      data_reg  <= load_data;
    end
  end

  // Compare against what the buffer will hold after this edge, so a read of
  // the same word accepted during the filling DATA cycle also hits.
  assign hit  = load ? (load_idx == lookup_idx) : (valid_reg && (idx_reg == lookup_idx));
  assign data = data_reg;

endmodule

// File: rtl/ahb_rom_ctrl.sv
// AHB slave front-end for a synchronous 32-bit ROM.
// Reads take 2+WAIT_CYCLES data-phase cycles; writes and out-of-range reads
// get a two-cycle ERROR response. Define ROM_LINEBUF_EN to add a one-word
// buffer that returns repeated reads of the same word with zero wait states.
module ahb_rom_ctrl
  import ahb_rom_pkg::*;
#(
  parameter int ROM_DEPTH   = 4096,
  parameter int WAIT_CYCLES = 0
)
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       HSEL_S,
  input  logic                       HREADY,
  input  logic [`AHB_TRANS_BITS-1:0] HTRANS,
  input  logic [`AHB_ADDR_BITS-1:0]  HADDR,
  input  logic                       HWRITE,
  input  logic [`AHB_SIZE_BITS-1:0]  HSIZE,
  output logic [`AHB_DATA_BITS-1:0]  HRDATA_S,
  output logic                       HREADY_S,
  output logic [`AHB_RESP_BITS-1:0]  HRESP_S,
  input  logic [31:0]                ROM_out,
  output logic                       ROM_enable,
  output logic                       ROM_read,
  output logic [31:0]                ROM_address
);

  localparam int IDX_W = rom_idx_bits(ROM_DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

  rom_state_e                state_reg;
  logic                      hready_reg;
  logic [`AHB_RESP_BITS-1:0] hresp_reg;
  logic                      rom_en_reg;
  logic                      hit_reg;
  logic [WAIT_CNT_W-1:0]     wait_cnt_reg;
  logic [ROM_WORD_IDX_W-1:0] idx_reg;

  logic [ROM_WORD_IDX_W-1:0] req_idx;
  logic                      can_accept;
  logic                      accept;
  logic                      req_bad;
  logic                      buf_hit;
  logic [31:0]               buf_data;
  logic                      unused_inputs;

  // Transfer size and byte lane never matter: the full word is always returned
  assign unused_inputs = ^{HSIZE, HADDR[1:0]};

  assign req_idx    = HADDR[`AHB_ADDR_BITS-1:2];
  // Only the last cycle of a data phase (or idle) may overlap a new address phase
  assign can_accept = (state_reg == IDLE) || (state_reg == DATA) || (state_reg == ERR2);
  assign accept     = can_accept && HSEL_S && HREADY &&
                      ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  // Writes and any index bit above the ROM size are refused
  assign req_bad    = HWRITE || (|(req_idx >> IDX_W));

`ifdef ROM_LINEBUF_EN
  logic buf_load;

  // The word in flight is captured as it is returned, unless it came from the buffer
  assign buf_load = (state_reg == DATA) && !hit_reg;

  ahb_rom_linebuf u_linebuf (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .load_idx   (idx_reg),
    .load_data  (ROM_out),
    .lookup_idx (req_idx),
    .hit        (buf_hit),
    .data       (buf_data)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  // Data-phase sequencer with registered bus and ROM strobe outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      hready_reg   <= 1'b1;
      hresp_reg    <= HRESP_OKAY;
      rom_en_reg   <= 1'b0;
      hit_reg      <= 1'b0;
      wait_cnt_reg <= '0;
      idx_reg      <= '0;
    end else begin
      rom_en_reg <= 1'b0;
      hit_reg    <= 1'b0;
      case (state_reg)
        IDLE, DATA, ERR2: begin
          if (accept) begin
            if (req_bad) begin
              state_reg  <= ERR1;
              hready_reg <= 1'b0;
              hresp_reg  <= HRESP_ERROR;
            end else if (buf_hit) begin
              state_reg  <= DATA;
              hit_reg    <= 1'b1;
              hready_reg <= 1'b1;
              hresp_reg  <= HRESP_OKAY;
              idx_reg    <= req_idx;
            end else begin
              state_reg  <= ACCESS;
              rom_en_reg <= 1'b1;
              hready_reg <= 1'b0;
              hresp_reg  <= HRESP_OKAY;
              idx_reg    <= req_idx;
            end
          end else begin
            // IDLE/BUSY, unselected, or cancelled after an error
            state_reg  <= IDLE;
            hready_reg <= 1'b1;
            hresp_reg  <= HRESP_OKAY;
          end
        end
        ACCESS: begin
          if (WAIT_CYCLES > 0) begin
            state_reg    <= WAIT;
            wait_cnt_reg <= WAIT_LOAD;
          end else begin
            state_reg  <= DATA;
            hready_reg <= 1'b1;
          end
        end
        WAIT: begin
          if (wait_cnt_reg == '0) begin
            state_reg  <= DATA;
            hready_reg <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 1'b1;
          end
        end
        ERR1: begin
          state_reg  <= ERR2;
          hready_reg <= 1'b1;
          hresp_reg  <= HRESP_ERROR;
        end
        default: begin
          state_reg  <= IDLE;
          hready_reg <= 1'b1;
          hresp_reg  <= HRESP_OKAY;
        end
      endcase
    end
  end

  // ROM data is only valid in DATA, so it is steered straight through there
  assign HRDATA_S    = (state_reg == DATA) ? (hit_reg ? buf_data : ROM_out) : '0;
  assign HREADY_S    = hready_reg;
  assign HRESP_S     = hresp_reg;
  assign ROM_enable  = rom_en_reg;
  assign ROM_read    = rom_en_reg;
  assign ROM_address = {idx_reg, 2'b00};

endmodule
